// File: rtl/counter_sweep_ctrl.sv
`timescale 1ns/1ps
// Triangle-sweep sequencer for an external 8-bit up/down counter.
// Drives cnt_enable/cnt_direction/cnt_rst, watches counter_out, and sweeps
// lo_limit..hi_limit with a dwell of dwell+1 cycles at each end, repeated
// max(cycles,1) times. Host handshake: start, stop, busy, done, cfg_err.
module counter_sweep_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned CYC_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo_limit,
  input  logic [WIDTH-1:0]   hi_limit,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CYC_W-1:0]   cycles,
  input  logic [WIDTH-1:0]   counter_out,
  output logic               cnt_enable,
  output logic               cnt_direction,
  output logic               cnt_rst,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [CYC_W-1:0]   sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRIME,
    S_UP,
    S_HOLD_TOP,
    S_DOWN,
    S_HOLD_BOT,
    S_DONE
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt;
  logic [CYC_W-1:0]   cyc_q;
  logic               accept, reject, sweep_inc;

  // Turn decisions look one count ahead because counter_out lags enable by
  // one cycle; this lands the counter exactly on each limit.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    reject        = 1'b0;
    sweep_inc     = 1'b0;
    cnt_enable    = 1'b0;
    cnt_direction = 1'b0;
    cnt_rst       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !stop) begin
          if (lo_limit < hi_limit) begin
            accept     = 1'b1;
            state_next = S_LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_LOAD: begin
        cnt_rst    = 1'b1;
        state_next = (lo_q != '0) ? S_PRIME : S_UP;
      end
      S_PRIME: begin
        cnt_enable    = 1'b1;
        cnt_direction = 1'b1;
        if (counter_out == lo_q - WIDTH'(1)) state_next = S_UP;
      end
      S_UP: begin
        cnt_enable    = 1'b1;
        cnt_direction = 1'b1;
        if (counter_out == hi_q - WIDTH'(1)) state_next = S_HOLD_TOP;
      end
      S_HOLD_TOP: begin
        if (dwell_cnt == dwell_q) state_next = S_DOWN;
      end
      S_DOWN: begin
        cnt_enable = 1'b1;
        if (counter_out == lo_q + WIDTH'(1)) state_next = S_HOLD_BOT;
      end
      S_HOLD_BOT: begin
        if (dwell_cnt == dwell_q) begin
          sweep_inc  = 1'b1;
          state_next = (sweep_cnt + CYC_W'(1) == cyc_q) ? S_DONE : S_UP;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (state != S_IDLE && stop) begin
      state_next = S_IDLE;
      sweep_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      dwell_q   <= '0;
      cyc_q     <= '0;
      sweep_cnt <= '0;
      dwell_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_next;
      cfg_err <= reject;
      if (accept) begin
        lo_q      <= lo_limit;
        hi_q      <= hi_limit;
        dwell_q   <= dwell;
        cyc_q     <= (cycles == '0) ? CYC_W'(1) : cycles;
        sweep_cnt <= '0;
      end else if (sweep_inc) begin
        sweep_cnt <= sweep_cnt + CYC_W'(1);
      end
      // Every hold is entered from a non-hold state, so clearing outside
      // the holds is the same as clearing on entry.
      if (state == S_HOLD_TOP || state == S_HOLD_BOT) begin
        dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end else begin
        dwell_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [7:0] lo_limit, hi_limit;
  logic [3:0] dwell, cycles;
  logic [7:0] counter_out;
  logic       cnt_enable, cnt_direction, cnt_rst, busy, done, cfg_err;
  logic [3:0] sweep_cnt;

  int errors = 0;
  int checks = 0;

  string      basic_tl = "LPPPUUUTTDDDBBUUUTTDDDBBFI";
  byte unsigned basic_cnt [1:26] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3,
                                     3, 3, 4, 5, 6, 6, 6, 5, 4, 3, 3, 3, 3};
  string      edge_tl = "LUTDBFI";
  byte unsigned edge_cnt [1:7] = '{0, 0, 1, 1, 0, 0, 0};

  counter_sweep_ctrl #(.WIDTH(8), .DWELL_W(4), .CYC_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .lo_limit(lo_limit), .hi_limit(hi_limit), .dwell(dwell), .cycles(cycles),
    .counter_out(counter_out), .cnt_enable(cnt_enable),
    .cnt_direction(cnt_direction), .cnt_rst(cnt_rst), .busy(busy),
    .done(done), .cfg_err(cfg_err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // Model of the external up/down counter; its reset is rst OR cnt_rst.
  always_ff @(posedge clk) begin
    if (rst || cnt_rst) counter_out <= '0;
    else if (cnt_enable) counter_out <= cnt_direction ? counter_out + 8'd1 : counter_out - 8'd1;
  end

  // Expected {cnt_rst, cnt_enable, busy, done} per state letter.
  function automatic logic [3:0] exp_outs(input byte c);
    case (c)
      "L":     return 4'b1010;
      "P":     return 4'b0110;
      "U":     return 4'b0110;
      "D":     return 4'b0110;
      "T":     return 4'b0010;
      "B":     return 4'b0010;
      "F":     return 4'b0011;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic exp_dir(input byte c);
    return (c == "D") ? 1'b0 : 1'b1;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] lo, input logic [7:0] hi,
                        input logic [3:0] dw, input logic [3:0] cy);
    lo_limit = lo; hi_limit = hi; dwell = dw; cycles = cy; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    lo_limit = '0; hi_limit = '0; dwell = '0; cycles = '0;
    tick(); tick();
    checks++;
    if ({cnt_rst, cnt_enable, cnt_direction, busy, done, cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 000000",
               {cnt_rst, cnt_enable, cnt_direction, busy, done, cfg_err});
    end
    checks++;
    if (sweep_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_sweep_cnt: got %0d want 0", sweep_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, cnt_rst, cnt_enable} !== 3'b000 || counter_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle: busy/rst/en %b counter %0d want 000 / 0",
               {busy, cnt_rst, cnt_enable}, counter_out);
    end
  endtask

  task automatic test_basic;
    logic [3:0] e;
    byte c;
    launch(8'd3, 8'd6, 4'd1, 4'd2);
    for (int k = 1; k <= 26; k++) begin
      c = basic_tl[k-1];
      e = exp_outs(c);
      checks++;
      if ({cnt_rst, cnt_enable, busy, done} !== e) begin
        errors++;
        $display("FAIL basic_outs cycle %0d: got %b want %b", k, {cnt_rst, cnt_enable, busy, done}, e);
      end
      if (e[2]) begin
        checks++;
        if (cnt_direction !== exp_dir(c)) begin
          errors++; $display("FAIL basic_dir cycle %0d: got %b want %b", k, cnt_direction, exp_dir(c));
        end
      end
      if (k > 1) begin
        checks++;
        if (counter_out !== basic_cnt[k]) begin
          errors++; $display("FAIL basic_counter cycle %0d: got %0d want %0d", k, counter_out, basic_cnt[k]);
        end
      end
      checks++;
      if (sweep_cnt !== ((k <= 14) ? 4'd0 : (k <= 24) ? 4'd1 : 4'd2)) begin
        errors++; $display("FAIL basic_sweep_cnt cycle %0d: got %0d", k, sweep_cnt);
      end
      tick();
    end
  endtask

  task automatic test_cfg_err;
    logic [7:0] los [2] = '{8'd5, 8'd9};
    logic [7:0] his [2] = '{8'd5, 8'd2};
    for (int t = 0; t < 2; t++) begin
      launch(los[t], his[t], 4'd1, 4'd1);
      checks++;
      if ({cfg_err, busy, cnt_rst} !== 3'b100) begin
        errors++;
        $display("FAIL cfg_err_pulse lo=%0d hi=%0d: err/busy/rst %b want 100", los[t], his[t], {cfg_err, busy, cnt_rst});
      end
      tick();
      checks++;
      if ({cfg_err, busy, cnt_rst} !== 3'b000) begin
        errors++;
        $display("FAIL cfg_err_clear lo=%0d hi=%0d: err/busy/rst %b want 000", los[t], his[t], {cfg_err, busy, cnt_rst});
      end
    end
  endtask

  task automatic test_edge_limits;
    logic [3:0] e;
    launch(8'd0, 8'd1, 4'd0, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      e = exp_outs(edge_tl[k-1]);
      checks++;
      if ({cnt_rst, cnt_enable, busy, done} !== e) begin
        errors++;
        $display("FAIL edge_outs cycle %0d: got %b want %b", k, {cnt_rst, cnt_enable, busy, done}, e);
      end
      if (k > 1) begin
        checks++;
        if (counter_out !== edge_cnt[k]) begin
          errors++; $display("FAIL edge_counter cycle %0d: got %0d want %0d", k, counter_out, edge_cnt[k]);
        end
      end
      checks++;
      if (sweep_cnt !== ((k <= 5) ? 4'd0 : 4'd1)) begin
        errors++; $display("FAIL edge_sweep_cnt cycle %0d: got %0d", k, sweep_cnt);
      end
      tick();
    end
  endtask

  task automatic test_top_range;
    byte c;
    int  ec;
    logic [3:0] e;
    launch(8'd250, 8'd255, 4'd2, 4'd1);
    for (int k = 1; k <= 269; k++) begin
      if (k == 1)        begin c = "L"; ec = -1; end
      else if (k <= 251) begin c = "P"; ec = k - 2; end
      else if (k <= 256) begin c = "U"; ec = 250 + (k - 252); end
      else if (k <= 259) begin c = "T"; ec = 255; end
      else if (k <= 264) begin c = "D"; ec = 255 - (k - 260); end
      else if (k <= 267) begin c = "B"; ec = 250; end
      else if (k == 268) begin c = "F"; ec = 250; end
      else               begin c = "I"; ec = 250; end
      e = exp_outs(c);
      checks++;
      if ({cnt_rst, cnt_enable, busy, done} !== e) begin
        errors++;
        $display("FAIL top_outs cycle %0d: got %b want %b", k, {cnt_rst, cnt_enable, busy, done}, e);
      end
      if (ec >= 0) begin
        checks++;
        if (counter_out !== ec[7:0]) begin
          errors++; $display("FAIL top_counter cycle %0d: got %0d want %0d", k, counter_out, ec);
        end
      end
      tick();
    end
  endtask

  task automatic test_abort;
    launch(8'd3, 8'd6, 4'd1, 4'd2);
    for (int k = 1; k < 11; k++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL abort_run cycle %0d: done/busy %b want 01", k, {done, busy});
      end
      tick();
    end
    checks++;
    if (counter_out !== 8'd5 || cnt_enable !== 1'b1 || cnt_direction !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_down: counter %0d en %b dir %b want 5 1 0", counter_out, cnt_enable, cnt_direction);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({busy, cnt_enable, done} !== 3'b000 || counter_out !== 8'd4) begin
        errors++;
        $display("FAIL abort_frozen +%0d: busy/en/done %b counter %0d want 000 / 4", k, {busy, cnt_enable, done}, counter_out);
      end
      tick();
    end
    launch(8'd3, 8'd6, 4'd1, 4'd2);
    checks++;
    if ({busy, cnt_rst} !== 2'b11) begin
      errors++; $display("FAIL abort_restart: busy/rst %b want 11", {busy, cnt_rst});
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL abort_load_stop: busy/done %b want 00", {busy, done});
    end
  endtask

  task automatic test_reset_and_ignores;
    logic [3:0] e;
    launch(8'd3, 8'd6, 4'd1, 4'd2);
    for (int k = 1; k <= 18; k++) begin
      e = exp_outs(basic_tl[k-1]);
      checks++;
      if ({cnt_rst, cnt_enable, busy, done} !== e) begin
        errors++;
        $display("FAIL ignore_outs cycle %0d: got %b want %b", k, {cnt_rst, cnt_enable, busy, done}, e);
      end
      if (k > 1) begin
        checks++;
        if (counter_out !== basic_cnt[k]) begin
          errors++; $display("FAIL ignore_counter cycle %0d: got %0d want %0d", k, counter_out, basic_cnt[k]);
        end
      end
      if (k == 3) begin
        lo_limit = 8'd0; hi_limit = 8'd2; dwell = 4'd0; cycles = 4'd1; start = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (k == 18) begin
        checks++;
        if (sweep_cnt !== 4'd1) begin
          errors++; $display("FAIL ignore_sweep_cnt: got %0d want 1", sweep_cnt);
        end
        rst = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    checks++;
    if ({busy, done, cnt_enable, cnt_rst} !== 4'b0000 || sweep_cnt !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset: busy/done/en/rst %b sweep_cnt %0d want 0000 / 0", {busy, done, cnt_enable, cnt_rst}, sweep_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++; $display("FAIL midrun_reset_quiet +%0d: busy/done %b want 00", k, {busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_err();
    test_edge_limits();
    test_top_range();
    test_abort();
    test_reset_and_ignores();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
